// File: rtl/kernel_driver.sv
// Host-side sequencer for a start/done kernel with an array side-port.
// It preloads a job, runs the kernel under a watchdog, and streams back the result and the final array.
module kernel_driver #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned ADDR_W  = 1,
  parameter int unsigned DEPTH   = 1,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_err,
  output logic              busy,
  output logic              r_enable,
  output logic [DATA_W-1:0] init_i,
  output logic              controlArr,
  output logic              controlArrWEnable_a,
  output logic [ADDR_W-1:0] controlArrAddr_a,
  output logic [DATA_W-1:0] controlArrWData_a,
  input  logic [DATA_W-1:0] controlArrRData_a,
  input  logic              w_enable,
  input  logic [DATA_W-1:0] result
);

  localparam int unsigned IDX_W = ADDR_W + 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
  localparam bit          HAS_ARR = (DEPTH != 0);
  localparam logic [IDX_W-1:0] LAST_IDX = HAS_ARR ? IDX_W'(DEPTH - 1) : '0;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, LOAD_INIT, LOAD_ARR, START, RUN,
    EMIT_RES, RD_ISSUE, RD_CAP, EMIT_ARR, EMIT_ERR
  } state_t;

  state_t            state, state_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [WD_W-1:0]   wd, wd_n;
  logic [DATA_W-1:0] init_n, data_n;
  logic              in_ready_n, out_valid_n, out_last_n, out_err_n;
  logic              busy_n, r_enable_n, ctrl_n;
  logic              in_acc, out_acc;

  assign in_acc  = in_valid && in_ready;
  assign out_acc = out_valid && out_ready;

  // Array write port follows the input stream directly so each accept is one write.
  assign controlArrWEnable_a = (state == LOAD_ARR) && in_valid;
  assign controlArrAddr_a    = idx[ADDR_W-1:0];
  assign controlArrWData_a   = in_data;

  // Next-state and next-output logic; outputs are registered decodes of state_n.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    wd_n    = wd;
    init_n  = init_i;
    data_n  = out_data;

    case (state)
      IDLE: state_n = LOAD_INIT;
      LOAD_INIT: begin
        if (in_acc) begin
          init_n  = in_data;
          idx_n   = '0;
          state_n = HAS_ARR ? LOAD_ARR : START;
        end
      end
      LOAD_ARR: begin
        if (in_acc) begin
          idx_n = idx + IDX_W'(1);
          if (idx == LAST_IDX) state_n = START;
        end
      end
      START: begin
        wd_n    = '0;
        state_n = RUN;
      end
      RUN: begin
        wd_n = wd + WD_W'(1);
        // A done flag wins over a simultaneous watchdog hit.
        if (w_enable) begin
          data_n  = result;
          state_n = EMIT_RES;
        end else if (wd == WD_LAST) begin
          data_n  = '0;
          state_n = EMIT_ERR;
        end
      end
      EMIT_RES: begin
        if (out_acc) begin
          idx_n   = '0;
          state_n = HAS_ARR ? RD_ISSUE : IDLE;
        end
      end
      RD_ISSUE: state_n = RD_CAP;
      RD_CAP: begin
        data_n  = controlArrRData_a;
        state_n = EMIT_ARR;
      end
      EMIT_ARR: begin
        if (out_acc) begin
          idx_n   = idx + IDX_W'(1);
          state_n = (idx == LAST_IDX) ? IDLE : RD_ISSUE;
        end
      end
      EMIT_ERR: begin
        if (out_acc) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    in_ready_n  = (state_n == LOAD_INIT) || (state_n == LOAD_ARR);
    out_valid_n = (state_n == EMIT_RES) || (state_n == EMIT_ARR) || (state_n == EMIT_ERR);
    out_err_n   = (state_n == EMIT_ERR);
    busy_n      = (state_n != IDLE);
    r_enable_n  = (state_n != RUN);
    // Port ownership is kept through RD_CAP so the read data is sampled from the driver's address.
    ctrl_n      = (state_n == LOAD_ARR) || (state_n == RD_ISSUE) || (state_n == RD_CAP);

    case (state_n)
      EMIT_RES: out_last_n = !HAS_ARR;
      EMIT_ARR: out_last_n = (idx_n == LAST_IDX);
      EMIT_ERR: out_last_n = 1'b1;
      default:  out_last_n = 1'b0;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      wd         <= '0;
      init_i     <= '0;
      out_data   <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_err    <= 1'b0;
      busy       <= 1'b0;
      r_enable   <= 1'b1;
      controlArr <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      wd         <= wd_n;
      init_i     <= init_n;
      out_data   <= data_n;
      in_ready   <= in_ready_n;
      out_valid  <= out_valid_n;
      out_last   <= out_last_n;
      out_err    <= out_err_n;
      busy       <= busy_n;
      r_enable   <= r_enable_n;
      controlArr <= ctrl_n;
    end
  end

endmodule

// File: tb/tb_kernel_driver.sv
// Bench for kernel_driver: a behavioural kernel (done 21 cycles after start) on the main instance,
// and a never-finishing stub on a second instance with a short watchdog.
module tb_kernel_driver;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, out_valid, out_ready, out_last, out_err, busy;
  logic [DW-1:0] in_data, out_data, init_i, wdata, rdata, result;
  logic          r_enable, ctrl, we, w_enable;
  logic [AW-1:0] addr;

  kernel_driver #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(1), .TIMEOUT(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_err(out_err), .busy(busy),
    .r_enable(r_enable), .init_i(init_i), .controlArr(ctrl),
    .controlArrWEnable_a(we), .controlArrAddr_a(addr), .controlArrWData_a(wdata),
    .controlArrRData_a(rdata), .w_enable(w_enable), .result(result)
  );

  logic          to_in_valid, to_in_ready, to_out_valid, to_out_ready, to_out_last, to_out_err;
  logic          to_busy, to_r_enable, to_ctrl, to_we;
  logic [DW-1:0] to_in_data, to_out_data, to_init_i, to_wdata;
  logic [AW-1:0] to_addr;
  logic [DW-1:0] to_rdata = '0;
  logic [DW-1:0] to_result = '0;
  logic          to_w_enable = 1'b0;

  kernel_driver #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(1), .TIMEOUT(16)) dut_to (
    .clk(clk), .rst_n(rst_n),
    .in_valid(to_in_valid), .in_ready(to_in_ready), .in_data(to_in_data),
    .out_valid(to_out_valid), .out_ready(to_out_ready), .out_data(to_out_data),
    .out_last(to_out_last), .out_err(to_out_err), .busy(to_busy),
    .r_enable(to_r_enable), .init_i(to_init_i), .controlArr(to_ctrl),
    .controlArrWEnable_a(to_we), .controlArrAddr_a(to_addr), .controlArrWData_a(to_wdata),
    .controlArrRData_a(to_rdata), .w_enable(to_w_enable), .result(to_result)
  );

  // Kernel model: result = 2*init for init >= 0, -3*init otherwise; also written to a[0].
  function automatic logic [63:0] kfun(input logic signed [63:0] x);
    return (x < 0) ? 64'(-3 * x) : 64'(2 * x);
  endfunction

  logic [DW-1:0] karr [0:1];
  logic [7:0]    kcnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kcnt     <= 8'd0;
      w_enable <= 1'b0;
      result   <= '0;
      rdata    <= '0;
    end else begin
      if (ctrl && we) karr[addr] <= wdata;
      rdata <= karr[addr];
      if (r_enable) begin
        kcnt     <= 8'd0;
        w_enable <= 1'b0;
      end else if (!w_enable) begin
        kcnt <= kcnt + 8'd1;
        if (kcnt == 8'd20) begin
          w_enable <= 1'b1;
          result   <= kfun(init_i);
          karr[0]  <= kfun(init_i);
        end
      end
    end
  end

  // Cycle counter and negedge monitors.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            wr_cnt = 0, bad_wr = 0, t_lastwr = 0, t_run = 0, t_wen = 0;
  logic [DW-1:0] wr_data = '0;
  logic [AW-1:0] wr_addr = '0;
  logic          prev_ren = 1'b1, prev_wen = 1'b0;
  logic          stall_pend = 1'b0, stall_last = 1'b0, stall_errb = 1'b0;
  logic [DW-1:0] stall_data = '0;
  int            stall_err = 0, stall_cnt = 0;
  logic [DW-1:0] rx_data [$];
  logic          rx_last [$];
  logic          rx_err  [$];

  always @(negedge clk) begin
    if (ctrl && we) begin
      wr_cnt   <= wr_cnt + 1;
      wr_data  <= wdata;
      wr_addr  <= addr;
      t_lastwr <= cyc;
      if (!(in_valid && in_ready)) bad_wr <= bad_wr + 1;
    end
    if (prev_ren && !r_enable) t_run <= cyc;
    if (w_enable && !prev_wen) t_wen <= cyc;
    prev_ren <= r_enable;
    prev_wen <= w_enable;
    if (!rst_n) begin
      stall_pend <= 1'b0;
    end else begin
      if (stall_pend && (!out_valid || out_data != stall_data ||
                         out_last != stall_last || out_err != stall_errb))
        stall_err <= stall_err + 1;
      stall_pend <= out_valid && !out_ready;
      stall_data <= out_data;
      stall_last <= out_last;
      stall_errb <= out_err;
      if (out_valid && !out_ready) stall_cnt <= stall_cnt + 1;
      if (out_valid && out_ready) begin
        rx_data.push_back(out_data);
        rx_last.push_back(out_last);
        rx_err.push_back(out_err);
      end
    end
  end

  int            to_acc = 0, to_hs = 0, t_run_to = 0, t_ov_to = 0;
  logic          to_seen = 1'b0, to_prev_ren = 1'b1;
  logic          to_e = 1'b0, to_l = 1'b0, to_ren = 1'b0, to_bsy = 1'b0;
  logic [DW-1:0] to_d = '1, to_wr_data = '0;
  logic [AW-1:0] to_wr_addr = '1;

  always @(negedge clk) begin
    if (to_in_valid && to_in_ready) to_acc <= to_acc + 1;
    if (to_ctrl && to_we) begin
      to_wr_data <= to_wdata;
      to_wr_addr <= to_addr;
    end
    if (to_prev_ren && !to_r_enable) t_run_to <= cyc;
    to_prev_ren <= to_r_enable;
    if (to_out_valid && !to_seen) begin
      to_seen <= 1'b1;
      t_ov_to <= cyc;
      to_d    <= to_out_data;
      to_e    <= to_out_err;
      to_l    <= to_out_last;
      to_ren  <= to_r_enable;
      to_bsy  <= to_busy;
    end
    if (to_out_valid && to_out_ready) to_hs <= to_hs + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check($sformatf("%s_in_ready", tag), 64'(in_ready), 64'd0);
    check($sformatf("%s_out_valid", tag), 64'(out_valid), 64'd0);
    check($sformatf("%s_out_last", tag), 64'(out_last), 64'd0);
    check($sformatf("%s_out_err", tag), 64'(out_err), 64'd0);
    check($sformatf("%s_busy", tag), 64'(busy), 64'd0);
    check($sformatf("%s_r_enable", tag), 64'(r_enable), 64'd1);
    check($sformatf("%s_ctrl", tag), 64'(ctrl), 64'd0);
    check($sformatf("%s_wen", tag), 64'(we), 64'd0);
    check($sformatf("%s_init_i", tag), init_i, 64'd0);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic push_word(input logic [63:0] w, input int gap);
    bit done;
    done = 1'b0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = w;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    check("push_accepted", 64'(done), 64'd1);
  endtask

  task automatic run_job(input string tag, input logic [63:0] init, input logic [63:0] a0,
                         input int gap, input bit toggle, input logic [63:0] exp_res);
    int base, wbase, bbase, n;
    base  = rx_data.size();
    wbase = wr_cnt;
    bbase = bad_wr;
    push_word(init, gap);
    push_word(a0, gap);
    check($sformatf("%s_init_i", tag), init_i, init);
    check($sformatf("%s_wr_cnt", tag), 64'(wr_cnt - wbase), 64'd1);
    check($sformatf("%s_wr_addr", tag), 64'(wr_addr), 64'd0);
    check($sformatf("%s_wr_data", tag), wr_data, a0);
    check($sformatf("%s_wr_on_accept", tag), 64'(bad_wr - bbase), 64'd0);
    out_ready = !toggle;
    n = 0;
    while (rx_data.size() < base + 2 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (toggle) out_ready = !out_ready;
    end
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check($sformatf("%s_words", tag), 64'(rx_data.size() - base), 64'd2);
    check($sformatf("%s_start_len", tag), 64'(t_run - t_lastwr), 64'd2);
    check($sformatf("%s_kernel_lat", tag), 64'(t_wen - t_run), 64'd21);
    if (rx_data.size() >= base + 2) begin
      check($sformatf("%s_res", tag), rx_data[base], exp_res);
      check($sformatf("%s_arr0", tag), rx_data[base+1], exp_res);
      check($sformatf("%s_last0", tag), 64'(rx_last[base]), 64'd0);
      check($sformatf("%s_last1", tag), 64'(rx_last[base+1]), 64'd1);
      check($sformatf("%s_err", tag), 64'({rx_err[base], rx_err[base+1]}), 64'd0);
    end
  endtask

  initial begin
    int base, sb, sc, n;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    to_in_valid = 1'b0; to_in_data = '0; to_out_ready = 1'b1;

    #12;
    check_reset("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    run_job("dep", 64'd5, 64'd99, 0, 1'b0, 64'd10);
    run_job("b2b_a", 64'd5, 64'd0, 0, 1'b0, 64'd10);
    run_job("b2b_b", -64'sd4, 64'd0, 0, 1'b0, 64'd12);

    sb = stall_err;
    sc = stall_cnt;
    run_job("toggle", 64'd5, 64'd0, 0, 1'b1, 64'd10);
    check("toggle_stable", 64'(stall_err - sb), 64'd0);
    check("toggle_stalled", 64'(stall_cnt > sc), 64'd1);

    run_job("gap", -64'sd4, 64'd33, 2, 1'b0, 64'd12);

    // Reset pulse while the kernel is running.
    base = rx_data.size();
    push_word(64'd5, 0);
    push_word(64'd0, 0);
    n = 0;
    while (r_enable && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("rst_run_entered", 64'(r_enable), 64'd0);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset("rst_run");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("rst_run_no_out", 64'(rx_data.size() - base), 64'd0);

    // Reset pulse while the array word is stalled.
    base = rx_data.size();
    push_word(64'd5, 0);
    push_word(64'd0, 0);
    n = 0;
    while (rx_data.size() == base && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("rst_arr_valid", 64'(out_valid), 64'd1);
    check("rst_arr_word", out_data, 64'd10);
    #2 rst_n = 1'b0;
    #1 check_reset("rst_arr");
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("rst_arr_no_out", 64'(rx_data.size() - base), 64'd1);

    run_job("post_rst", 64'd5, 64'd0, 0, 1'b0, 64'd10);

    // Watchdog abort on the stub-kernel instance.
    to_in_data  = 64'd7;
    to_in_valid = 1'b1;
    n = 0;
    while (to_acc < 2 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    to_in_valid = 1'b0;
    n = 0;
    while (!to_seen && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (5) @(posedge clk);
    #1;
    check("to_seen", 64'(to_seen), 64'd1);
    check("to_init_i", to_init_i, 64'd7);
    check("to_wr", {to_wr_data[62:0], to_wr_addr}, 64'd14);
    check("to_latency", 64'(t_ov_to - t_run_to), 64'd16);
    check("to_data", to_d, 64'd0);
    check("to_err", 64'(to_e), 64'd1);
    check("to_last", 64'(to_l), 64'd1);
    check("to_r_enable", 64'(to_ren), 64'd1);
    check("to_busy", 64'(to_bsy), 64'd1);
    check("to_handshakes", 64'(to_hs), 64'd1);
    check("to_valid_drop", 64'(to_out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
